// File: rtl/pipe_pkg.sv
// Shared types and constants for the decode->execute pipeline stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

    localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0800;
    localparam int          STALL_W           = 16;

endpackage

// File: rtl/pipe_entry_reg.sv
// One storage entry of the ID/EX stage: payload, side-effect bits, instruction and valid flag.
module pipe_entry_reg #(
    parameter int DATA_W  = 64,
    parameter int SE_W    = 4,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               load_i,
    input  logic [DATA_W-1:0]  data_i,
    input  logic [SE_W-1:0]    se_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic               valid_o,
    output logic [DATA_W-1:0]  data_o,
    output logic [SE_W-1:0]    se_o,
    output logic [INSTR_W-1:0] instr_o
);

    logic               valid_q;
    logic [DATA_W-1:0]  data_q;
    logic [SE_W-1:0]    se_q;
    logic [INSTR_W-1:0] instr_q;

    // Clear only drops the valid flag; the contents are left as they were.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            se_q    <= '0;
            instr_q <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            se_q    <= se_i;
            instr_q <= instr_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign se_o    = se_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/idex_pipe_stage.sv
// Handshaked ID/EX pipeline register with flush and bubble squashing.
// PIPE_SKID_EN selects the two-entry skid buffer with registered in_ready.
module idex_pipe_stage
    import pipe_pkg::*;
#(
    parameter int                 DATA_W    = 64,
    parameter int                 SE_W      = 4,
    parameter int                 INSTR_W   = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SE_W-1:0]    in_se,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [SE_W-1:0]    out_se,
    output logic [INSTR_W-1:0] out_instr,
    output logic [STALL_W-1:0] stall_cnt
);

    pipe_state_e        state_q, state_d;
    logic               in_fire, out_fire;
    logic               main_ld, main_clr, main_vld;
    logic [DATA_W-1:0]  main_data_d, main_data;
    logic [SE_W-1:0]    main_se_d, main_se;
    logic [INSTR_W-1:0] main_instr_d, main_instr;
    logic [STALL_W-1:0] stall_q;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_valid = main_vld;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= EMPTY;
        else      state_q <= state_d;
    end

`ifdef PIPE_SKID_EN
    logic               skid_ld, skid_clr, skid_vld, main_from_skid;
    logic [DATA_W-1:0]  skid_data;
    logic [SE_W-1:0]    skid_se;
    logic [INSTR_W-1:0] skid_instr;

    // The skid valid flag is itself a register, so in_ready never sees out_ready.
    assign in_ready = !skid_vld;

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: if (in_fire) begin
                main_ld = 1'b1;
                state_d = FULL;
            end
            FULL: begin
                if (in_fire && out_fire) begin
                    main_ld = 1'b1;
                end else if (in_fire) begin
                    skid_ld = 1'b1;
                    state_d = SKID;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            SKID: if (out_fire) begin
                main_ld        = 1'b1;
                main_from_skid = 1'b1;
                state_d        = FULL;
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_ld = 1'b0;
            skid_ld = 1'b0;
        end
    end

    assign skid_clr     = flush || main_from_skid;
    assign main_data_d  = main_from_skid ? skid_data  : in_data;
    assign main_se_d    = main_from_skid ? skid_se    : in_se;
    assign main_instr_d = main_from_skid ? skid_instr : in_instr;

    pipe_entry_reg #(
        .DATA_W  (DATA_W),
        .SE_W    (SE_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (skid_clr),
        .load_i  (skid_ld),
        .data_i  (in_data),
        .se_i    (in_se),
        .instr_i (in_instr),
        .valid_o (skid_vld),
        .data_o  (skid_data),
        .se_o    (skid_se),
        .instr_o (skid_instr)
    );
`else
    assign in_ready = !main_vld || out_ready;

    always_comb begin
        state_d = state_q;
        main_ld = 1'b0;
        case (state_q)
            EMPTY: if (in_fire) begin
                main_ld = 1'b1;
                state_d = FULL;
            end
            FULL: begin
                if (in_fire)       main_ld = 1'b1;
                else if (out_fire) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_ld = 1'b0;
        end
    end

    assign main_data_d  = in_data;
    assign main_se_d    = in_se;
    assign main_instr_d = in_instr;
`endif

    // Head empties when it is consumed without a replacement arriving.
    assign main_clr = flush || (out_fire && !main_ld);

    pipe_entry_reg #(
        .DATA_W  (DATA_W),
        .SE_W    (SE_W),
        .INSTR_W (INSTR_W)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (main_clr),
        .load_i  (main_ld),
        .data_i  (main_data_d),
        .se_i    (main_se_d),
        .instr_i (main_instr_d),
        .valid_o (main_vld),
        .data_o  (main_data),
        .se_o    (main_se),
        .instr_o (main_instr)
    );

    assign out_data  = main_data;
    assign out_se    = main_vld ? main_se : '0;
    assign out_instr = main_vld ? main_instr : NOP_INSTR;

    always_ff @(posedge clk) begin
        if (!rst)
            stall_q <= '0;
        else if (out_valid && !out_ready && (stall_q != {STALL_W{1'b1}}))
            stall_q <= stall_q + 1'b1;
    end

    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_idex_pipe_stage.sv
// Randomised scoreboard bench for idex_pipe_stage against a FIFO-queue reference model.
module tb_idex_pipe_stage;

    localparam int DW = 64;
    localparam int SW = 4;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, flush, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [SW-1:0] in_se, out_se;
    logic [IW-1:0] in_instr, out_instr;
    logic [15:0]   stall_cnt;

    always #5 clk = ~clk;

    idex_pipe_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_se     (in_se),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_se    (out_se),
        .out_instr (out_instr),
        .stall_cnt (stall_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [SW-1:0] se;
        logic [IW-1:0] ins;
    } ent_t;

`ifdef PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    ent_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   stall_m = 0;
    bit   chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference model: a FIFO of capacity CAP; outputs compared before each edge.
    bit   m_vld, m_rdy, m_in_fire, m_out_fire;
    ent_t m_e;
    always @(negedge clk) begin
        m_vld = exp_q.size() > 0;
        if (CAP == 2) m_rdy = exp_q.size() < 2;
        else          m_rdy = !m_vld || out_ready;
        if (chk_en) begin
            chk("out_valid", 64'(out_valid), 64'(m_vld));
            chk("in_ready", 64'(in_ready), 64'(m_rdy));
            chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
            if (m_vld) begin
                chk("out_instr", 64'(out_instr), 64'(exp_q[0].ins));
                chk("out_data", out_data, exp_q[0].d);
                chk("out_se", 64'(out_se), 64'(exp_q[0].se));
            end else begin
                chk("bubble_se", 64'(out_se), 64'(0));
                chk("bubble_instr", 64'(out_instr), 64'(16'h0800));
            end
        end
        if (!rst) begin
            exp_q.delete();
            stall_m = 0;
        end else begin
            m_in_fire  = in_valid && m_rdy;
            m_out_fire = m_vld && out_ready;
            if (m_vld && !out_ready && stall_m < 65535) stall_m++;
            if (m_out_fire) void'(exp_q.pop_front());
            if (flush) exp_q.delete();
            else if (m_in_fire) begin
                m_e.d   = in_data;
                m_e.se  = in_se;
                m_e.ins = in_instr;
                exp_q.push_back(m_e);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_data = '0; in_se = '0; in_instr = '0;
        cyc();
        cyc();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_instr", 64'(out_instr), 64'(16'h0800));
        chk("rst_out_se", 64'(out_se), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
        chk("rst_out_data", out_data, 64'(0));
        chk_en = 1'b1;
        rst = 1'b1;

        // Streaming: one entry per cycle, visible one cycle after acceptance.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_instr = 16'h1000 + 16'(i);
            in_data  = {$urandom, $urandom};
            in_se    = 4'($urandom);
            cyc();
            chk("stream_valid", 64'(out_valid), 64'(1));
            chk("stream_instr", 64'(out_instr), 64'(16'h1000 + i));
        end
        in_valid = 1'b0;
        repeat (3) cyc();

        // Back-pressure with a clean counter.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'h2000;
        in_se     = 4'h3;
        cyc();
        in_instr = 16'h2001;
        repeat (5) cyc();
        in_valid = 1'b0;
        chk("bp_stall_cnt", 64'(stall_cnt), 64'(5));
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_head", 64'(out_instr), 64'(16'h2000));
        out_ready = 1'b1;
        cyc();
        chk("bp_second", 64'(out_instr), (CAP == 2) ? 64'(16'h2001) : 64'(16'h0800));
        repeat (3) cyc();

        // Flush while full: held entry and same-cycle input both vanish.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_se     = 4'b1111;
        in_instr  = 16'h3000;
        cyc();
        in_instr = 16'hDEAD;
        flush    = 1'b1;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'(0));
        chk("flush_se", 64'(out_se), 64'(0));
        chk("flush_instr", 64'(out_instr), 64'(16'h0800));
        out_ready = 1'b1;
        repeat (3) cyc();

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 20) == 0;
            rst       = ($urandom % 150) != 0;
            in_data   = {$urandom, $urandom};
            in_se     = 4'($urandom);
            in_instr  = 16'($urandom);
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; rst = 1'b1;
        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 10) begin
                cyc();
                n++;
            end
            if (exp_q.size() != 0) begin
                total++;
                bad++;
                $display("FAIL drain_timeout: left %0d expected 0", exp_q.size());
            end
        end

        // Counter saturation.
        do_reset();
        in_valid  = 1'b1;
        in_instr  = 16'h4000;
        out_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        repeat (70000) cyc();
        chk("sat_stall", 64'(stall_cnt), 64'(16'hFFFF));
        repeat (3) cyc();
        chk("sat_hold", 64'(stall_cnt), 64'(16'hFFFF));
        do_reset();
        chk("sat_reset_clear", 64'(stall_cnt), 64'(0));
        chk("sat_reset_valid", 64'(out_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
